// File: rtl/spi_mem_master_if.sv
// Request/response handshake bundle shared by spi_mem_master and its requester.
interface spi_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_len;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/spi_mem_master.sv
// SPI master for serial memories: one command byte, ADDR_BYTES address bytes,
// then 1..MAX_BYTES data bytes, with programmable chip-select setup/hold.
module spi_mem_master #(
  parameter int CLK_DIV    = 2,
  parameter int NUM_CS     = 2,
  parameter int ADDR_BYTES = 3,
  parameter int MAX_BYTES  = 4,
  parameter int CPOL       = 0,
  parameter int CS_SETUP   = 4,
  parameter int CS_HOLD    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_mem_master_if.slave   bus,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_CS-1:0] cs_n_o
);

  localparam int         TXW        = 8 * (1 + ADDR_BYTES + MAX_BYTES);
  localparam logic [6:0] HDR_BITS   = 7'(8 * (1 + ADDR_BYTES));
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic       CPOL_BIT   = 1'(CPOL);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RESP} state_t;

  state_t         state_q, state_d;
  logic           sclk_q, sclk_d;
  logic [7:0]     halfCnt_q, halfCnt_d;
  logic [6:0]     bitCnt_q, bitCnt_d;
  logic [TXW-1:0] txShift_q, txShift_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           write_q, write_d;
  logic [2:0]     len_q, len_d;
  logic [1:0]     csSel_q, csSel_d;

  logic [8*MAX_BYTES-1:0] dataOut;
  logic [TXW-1:0]         txLoad;
  logic                   reject;
  logic [6:0]             nBits;
  logic [4:0]             dataIdx;
  logic                   unusedBits;

  // Write data goes out byte0 first; reads clock out zeros during the data phase.
  always_comb begin
    dataOut = '0;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (bus.req_write) dataOut[8*(MAX_BYTES-1-b) +: 8] = bus.req_wdata[8*b +: 8];
    end
  end

  assign txLoad     = {(bus.req_write ? 8'h02 : 8'h03), bus.req_addr[8*ADDR_BYTES-1:0], dataOut};
  assign reject     = (bus.req_addr[31:24] >= 8'(NUM_CS)) || (bus.req_len == 3'd0) ||
                      (bus.req_len > 3'(MAX_BYTES));
  assign nBits      = HDR_BITS + {1'b0, len_q, 3'b000};
  assign dataIdx    = 5'(bitCnt_q - HDR_BITS);
  assign unusedBits = ^{bus.req_addr, bus.req_wdata};

  // bitCnt counts rising edges, so a falling edge before any sample (CPOL=1)
  // leaves the first bit on mosi.
  always_comb begin
    state_d   = state_q;
    sclk_d    = sclk_q;
    halfCnt_d = halfCnt_q;
    bitCnt_d  = bitCnt_q;
    txShift_d = txShift_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    write_d   = write_q;
    len_d     = len_q;
    csSel_d   = csSel_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d   = bus.req_write;
          len_d     = bus.req_len;
          csSel_d   = bus.req_addr[25:24];
          txShift_d = txLoad;
          rdata_d   = '0;
          halfCnt_d = '0;
          bitCnt_d  = '0;
          sclk_d    = CPOL_BIT;
          err_d     = reject;
          state_d   = reject ? RESP : SETUP;
        end
      end
      SETUP: begin
        if (halfCnt_q == SETUP_LAST) begin
          halfCnt_d = '0;
          state_d   = SHIFT;
        end else begin
          halfCnt_d = halfCnt_q + 8'd1;
        end
      end
      SHIFT: begin
        if (halfCnt_q == DIV_LAST) begin
          halfCnt_d = '0;
          sclk_d    = ~sclk_q;
          if (!sclk_q) begin
            bitCnt_d = bitCnt_q + 7'd1;
            if (!write_q && bitCnt_q >= HDR_BITS) rdata_d[{dataIdx[4:3], ~dataIdx[2:0]}] = miso_i;
          end else if (bitCnt_q != 7'd0) begin
            txShift_d = txShift_q << 1;
          end
          if ((sclk_q != CPOL_BIT) && (bitCnt_d == nBits)) state_d = HOLD;
        end else begin
          halfCnt_d = halfCnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (halfCnt_q == HOLD_LAST) begin
          halfCnt_d = '0;
          state_d   = RESP;
        end else begin
          halfCnt_d = halfCnt_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sclk_q    <= CPOL_BIT;
      halfCnt_q <= '0;
      bitCnt_q  <= '0;
      txShift_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      len_q     <= '0;
      csSel_q   <= '0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_d;
      halfCnt_q <= halfCnt_d;
      bitCnt_q  <= bitCnt_d;
      txShift_q <= txShift_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      write_q   <= write_d;
      len_q     <= len_d;
      csSel_q   <= csSel_d;
    end
  end

  // req_ready is gated by rst_n so it is low during reset and rises as soon as reset releases.
  assign bus.req_ready = (state_q == IDLE) && rst_n;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign sclk_o        = sclk_q;
  assign mosi_o        = (state_q == SETUP || state_q == SHIFT) ? txShift_q[TXW-1] : 1'b0;
  assign cs_n_o        = (state_q == SETUP || state_q == SHIFT || state_q == HOLD) ?
                         ~(NUM_CS'(1) << csSel_q) : {NUM_CS{1'b1}};

endmodule
